// File: rtl/wb_stage_mlane_pkg.sv
// wb_stage_mlane_pkg: shared constants for the multi-lane writeback stage.
//   Stall-bus polarity (Stop/NoStop), stall-bus width, and default lane
//   widths for the MEM->WB and WB->RF/ID buses at the default parameters.
package wb_stage_mlane_pkg;

    localparam logic Stop    = 1'b1;
    localparam logic NoStop  = 1'b0;
    localparam int   STALL_W = 6;

    // Default geometry; modules recompute these from their own parameters.
    localparam int DEF_LANES  = 2;
    localparam int DEF_PC_W   = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    localparam int WB_LANE_WD    = DEF_PC_W + 1 + DEF_ADDR_W + DEF_DATA_W;
    localparam int WB_RF_LANE_WD = 1 + DEF_ADDR_W + DEF_DATA_W;
    localparam int MEM_TO_WB_WD  = DEF_LANES * WB_LANE_WD;
    localparam int WB_TO_RF_WD   = DEF_LANES * WB_RF_LANE_WD;

endpackage

// File: rtl/wb_stage_mlane_if.sv
// wb_stage_mlane_if: pipeline-side bundle of the writeback stage.
//   master: pipeline control / testbench (drives stall, flush, mem_to_wb_bus)
//   slave : wb_stage_mlane (drives RF/ID buses, stall request, difftest trace)
interface wb_stage_mlane_if
    import wb_stage_mlane_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int PC_W   = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int LW = PC_W + 1 + ADDR_W + DATA_W;
    localparam int RW = 1 + ADDR_W + DATA_W;

    logic [STALL_W-1:0]  stall;
    logic                flush;
    logic [LANES*LW-1:0] mem_to_wb_bus;
    logic [LANES*RW-1:0] wb_to_rf_bus;
    logic [LANES*RW-1:0] wb_to_id_bus;
    logic                stallreq_wb;
    logic [PC_W-1:0]     debug_wb_pc;
    logic [3:0]          debug_wb_rf_wen;
    logic [ADDR_W-1:0]   debug_wb_rf_wnum;
    logic [DATA_W-1:0]   debug_wb_rf_wdata;

    modport master (
        output stall, flush, mem_to_wb_bus,
        input  wb_to_rf_bus, wb_to_id_bus, stallreq_wb,
        input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

    modport slave (
        input  stall, flush, mem_to_wb_bus,
        output wb_to_rf_bus, wb_to_id_bus, stallreq_wb,
        output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

endinterface

// File: rtl/wb_stage_mlane_trace_fifo.sv
// wb_trace_fifo: multi-push (up to LANES per cycle), single-pop FIFO.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   i_push_cnt   : number of valid entries in i_push_data (entries 0..cnt-1)
//   i_push_data  : entries to enqueue, index 0 first
//   i_pop        : dequeue head (ignored when empty)
//   o_head       : current head entry
//   o_cnt        : occupancy
module wb_trace_fifo #(
    parameter int LANES = 2,
    parameter int DEPTH = 4,
    parameter int W     = 69,
    parameter int CNT_W = $clog2(DEPTH) + 1,
    parameter int PC_W  = $clog2(LANES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PC_W-1:0]           i_push_cnt,
    input  logic [LANES-1:0][W-1:0]   i_push_data,
    input  logic                      i_pop,
    output logic [W-1:0]              o_head,
    output logic [CNT_W-1:0]          o_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pop;

    function automatic logic [AW-1:0] wrap(input logic [AW-1:0] p, input int n);
        return AW'((int'(p) + n) % DEPTH);
    endfunction

    assign w_pop  = i_pop && (r_cnt != '0);
    assign o_head = r_mem[r_rd_ptr];
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            for (int j = 0; j < LANES; j++) begin
                if (j < int'(i_push_cnt))
                    r_mem[wrap(r_wr_ptr, j)] <= i_push_data[j];
            end
            r_wr_ptr <= wrap(r_wr_ptr, int'(i_push_cnt));
            if (w_pop)
                r_rd_ptr <= wrap(r_rd_ptr, 1);
            r_cnt <= r_cnt + CNT_W'(i_push_cnt) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/wb_stage_mlane.sv
// wb_stage_mlane: MEM->WB pipeline register for LANES retirement lanes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of wb_stage_mlane_if
//     stall/flush/mem_to_wb_bus in; wb_to_rf_bus / wb_to_id_bus out (same
//     content, from the register); stallreq_wb out (trace FIFO near full);
//     debug_wb_* out: one retirement per cycle, lanes serialised in order.
module wb_stage_mlane
    import wb_stage_mlane_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int PC_W        = 32,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int TRACE_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    wb_stage_mlane_if.slave bus
);
    localparam int LW    = PC_W + 1 + ADDR_W + DATA_W;
    localparam int RW    = 1 + ADDR_W + DATA_W;
    localparam int TW    = PC_W + ADDR_W + DATA_W;   // trace entry {pc, waddr, wdata}
    localparam int CNT_W = $clog2(TRACE_DEPTH) + 1;
    localparam int NPW   = $clog2(LANES + 1);

    logic [LANES*LW-1:0]      r_wb_bus;
    logic                     r_new;
    logic [LANES-1:0]         w_we;
    logic [LANES-1:0][TW-1:0] w_entry;
    logic [LANES-1:0][TW-1:0] w_push_data;
    logic [NPW-1:0]           w_push_cnt;
    logic [TW-1:0]            w_direct;
    logic                     w_direct_vld;
    logic [TW-1:0]            w_head;
    logic [TW-1:0]            w_load_entry;
    logic                     w_pop;
    logic                     w_load;
    logic [CNT_W-1:0]         w_fifo_cnt;
    logic [CNT_W-1:0]         w_occ_nxt;
    logic                     r_stallreq;
    logic [PC_W-1:0]          r_dbg_pc;
    logic [3:0]               r_dbg_wen;
    logic [ADDR_W-1:0]        r_dbg_wnum;
    logic [DATA_W-1:0]        r_dbg_wdata;
    logic                     w_unused_stall;

    assign w_unused_stall = ^bus.stall[3:0];

    // WB register: flush > bubble > capture > hold. new_r marks a fresh
    // capture so a held register is traced only once.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_wb_bus <= '0;
            r_new    <= 1'b0;
        end else if (bus.stall[4] == Stop && bus.stall[5] == NoStop) begin
            r_wb_bus <= '0;
            r_new    <= 1'b0;
        end else if (bus.stall[4] == NoStop) begin
            r_wb_bus <= bus.mem_to_wb_bus;
            r_new    <= 1'b1;
        end else begin
            r_new    <= 1'b0;
        end
    end

    // Lane layout {pc, we, waddr, wdata}; the low RW bits are the RF write.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int B = i * LW;
        assign w_we[i]    = r_wb_bus[B + ADDR_W + DATA_W];
        assign w_entry[i] = {r_wb_bus[B + RW +: PC_W], r_wb_bus[B +: ADDR_W + DATA_W]};
        assign bus.wb_to_rf_bus[i*RW +: RW] = r_wb_bus[B +: RW];
        assign bus.wb_to_id_bus[i*RW +: RW] = r_wb_bus[B +: RW];
    end

    // Candidates in lane order. With an empty FIFO the oldest one bypasses
    // straight to the debug registers; everything else is compacted into
    // consecutive push slots so the FIFO preserves program order.
    always_comb begin
        w_push_data  = '0;
        w_push_cnt   = '0;
        w_direct     = '0;
        w_direct_vld = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (r_new && w_we[i]) begin
                if (w_fifo_cnt == '0 && !w_direct_vld) begin
                    w_direct     = w_entry[i];
                    w_direct_vld = 1'b1;
                end else begin
                    w_push_data[w_push_cnt] = w_entry[i];
                    w_push_cnt              = w_push_cnt + NPW'(1);
                end
            end
        end
    end

    assign w_pop        = (w_fifo_cnt != '0);
    assign w_load       = w_pop || w_direct_vld;
    assign w_load_entry = w_pop ? w_head : w_direct;
    assign w_occ_nxt    = w_fifo_cnt + CNT_W'(w_push_cnt) - CNT_W'(w_pop);

    wb_trace_fifo #(
        .LANES (LANES),
        .DEPTH (TRACE_DEPTH),
        .W     (TW),
        .CNT_W (CNT_W),
        .PC_W  (NPW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push_cnt  (w_push_cnt),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_cnt       (w_fifo_cnt)
    );

    // Raise the stall one cycle ahead: leaving at most DEPTH-LANES entries
    // lets the next capture push a full set of lanes safely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallreq  <= 1'b0;
            r_dbg_pc    <= '0;
            r_dbg_wen   <= '0;
            r_dbg_wnum  <= '0;
            r_dbg_wdata <= '0;
        end else begin
            r_stallreq <= (w_occ_nxt > CNT_W'(TRACE_DEPTH - LANES));
            if (w_load) begin
                r_dbg_pc    <= w_load_entry[TW-1 -: PC_W];
                r_dbg_wen   <= 4'hF;
                r_dbg_wnum  <= w_load_entry[DATA_W +: ADDR_W];
                r_dbg_wdata <= w_load_entry[DATA_W-1:0];
            end else begin
                r_dbg_wen   <= 4'h0;
            end
        end
    end

    assign bus.stallreq_wb       = r_stallreq;
    assign bus.debug_wb_pc       = r_dbg_pc;
    assign bus.debug_wb_rf_wen   = r_dbg_wen;
    assign bus.debug_wb_rf_wnum  = r_dbg_wnum;
    assign bus.debug_wb_rf_wdata = r_dbg_wdata;

endmodule

// File: tb/tb_wb_stage_mlane.sv
// Directed bench for wb_stage_mlane: a LANES=1 and a LANES=2 instance.
module tb_wb_stage_mlane;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   fails   = 0;
    int   hold_cnt;

    always #5 clk = ~clk;

    wb_stage_mlane_if #(.LANES(1)) if1 ();
    wb_stage_mlane_if #(.LANES(2)) if2 ();

    wb_stage_mlane #(.LANES(1), .TRACE_DEPTH(4)) d1 (.clk(clk), .rst(rst), .bus(if1.slave));
    wb_stage_mlane #(.LANES(2), .TRACE_DEPTH(4)) d2 (.clk(clk), .rst(rst), .bus(if2.slave));

    function automatic logic [69:0] ln(input logic [31:0] pc, input logic we,
                                       input logic [4:0] a, input logic [31:0] d);
        return {pc, we, a, d};
    endfunction

    function automatic logic [37:0] rl(input logic we, input logic [4:0] a, input logic [31:0] d);
        return {we, a, d};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle overflow watch on the dual-lane FIFO, then advance one edge.
    task automatic step();
        @(negedge clk);
        if (!rst)
            chk("no_overflow", 128'(int'(d2.w_fifo_cnt) + int'(d2.w_push_cnt) - int'(d2.w_pop) <= 4), 128'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if1.stall = '0; if1.flush = 1'b0; if1.mem_to_wb_bus = '0;
        if2.stall = '0; if2.flush = 1'b0; if2.mem_to_wb_bus = '0;
        step(); step();
        chk("rst_wen",   if2.debug_wb_rf_wen, 0);
        chk("rst_pc",    if2.debug_wb_pc, 0);
        chk("rst_sr",    if2.stallreq_wb, 0);
        chk("rst_rf",    if2.wb_to_rf_bus, 0);
        chk("rst_id",    if2.wb_to_id_bus, 0);
        chk("rst_l1wen", if1.debug_wb_rf_wen, 0);
        rst = 1'b0;

        // single lane
        if1.mem_to_wb_bus = ln(32'hBFC0_0000, 1'b1, 5'd8, 32'h1234);
        step();
        chk("l1_rf",     if1.wb_to_rf_bus, rl(1'b1, 5'd8, 32'h1234));
        chk("l1_id",     if1.wb_to_id_bus, rl(1'b1, 5'd8, 32'h1234));
        chk("l1_wen_t0", if1.debug_wb_rf_wen, 0);
        if1.mem_to_wb_bus = '0;
        step();
        chk("l1_pc",     if1.debug_wb_pc, 32'hBFC0_0000);
        chk("l1_wen",    if1.debug_wb_rf_wen, 4'hF);
        chk("l1_wnum",   if1.debug_wb_rf_wnum, 5'd8);
        chk("l1_wdata",  if1.debug_wb_rf_wdata, 32'h1234);
        chk("l1_sr",     if1.stallreq_wb, 0);
        step();
        chk("l1_wen_t2", if1.debug_wb_rf_wen, 0);
        chk("l1_pc_hold", if1.debug_wb_pc, 32'hBFC0_0000);

        // dual retire, empty FIFO
        if2.mem_to_wb_bus = {ln(32'h104, 1'b1, 5'd3, 32'd7), ln(32'h100, 1'b1, 5'd2, 32'd5)};
        step();
        chk("dual_rf", if2.wb_to_rf_bus, {rl(1'b1, 5'd3, 32'd7), rl(1'b1, 5'd2, 32'd5)});
        chk("dual_id", if2.wb_to_id_bus, {rl(1'b1, 5'd3, 32'd7), rl(1'b1, 5'd2, 32'd5)});
        if2.mem_to_wb_bus = '0;
        step();
        chk("dual_pc0",   if2.debug_wb_pc, 32'h100);
        chk("dual_wnum0", if2.debug_wb_rf_wnum, 5'd2);
        chk("dual_data0", if2.debug_wb_rf_wdata, 32'd5);
        chk("dual_wen0",  if2.debug_wb_rf_wen, 4'hF);
        step();
        chk("dual_pc1",   if2.debug_wb_pc, 32'h104);
        chk("dual_wnum1", if2.debug_wb_rf_wnum, 5'd3);
        chk("dual_data1", if2.debug_wb_rf_wdata, 32'd7);
        step();
        chk("dual_wen_t3", if2.debug_wb_rf_wen, 0);

        // back-pressure: four dual captures, then hold while the FIFO drains
        for (int c = 0; c < 10; c++) begin
            if (c < 4) begin
                if2.stall = '0;
                if2.mem_to_wb_bus = {ln(32'h300 + 32'(8*c + 4), 1'b1, 5'(2*c + 2), 32'(2*c + 17)),
                                     ln(32'h300 + 32'(8*c),     1'b1, 5'(2*c + 1), 32'(2*c + 16))};
            end else begin
                if2.stall = 6'b110000;
            end
            step();
            chk($sformatf("bp_sr_%0d", c), if2.stallreq_wb, (c >= 3 && c <= 5) ? 1 : 0);
            if (c >= 1 && c <= 8) begin
                chk($sformatf("bp_pc_%0d", c),  if2.debug_wb_pc, 32'h300 + 32'(4*(c - 1)));
                chk($sformatf("bp_wen_%0d", c), if2.debug_wb_rf_wen, 4'hF);
            end
            if (c == 9)
                chk("bp_wen_end", if2.debug_wb_rf_wen, 0);
        end

        // hold: traced once, RF write stays asserted
        if2.stall = '0;
        if2.mem_to_wb_bus = {ln(32'h0, 1'b0, 5'd0, 32'd0), ln(32'h200, 1'b1, 5'd4, 32'h22)};
        step();
        if2.stall = 6'b110000;
        hold_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (if2.debug_wb_rf_wen == 4'hF && if2.debug_wb_pc == 32'h200) hold_cnt++;
            if (c <= 3)
                chk($sformatf("hold_rf_%0d", c), if2.wb_to_rf_bus[37:0], rl(1'b1, 5'd4, 32'h22));
        end
        chk("hold_once", hold_cnt, 1);

        // bubble
        if2.stall = 6'b010000;
        step();
        chk("bubble_rf", if2.wb_to_rf_bus, 0);
        chk("bubble_id", if2.wb_to_id_bus, 0);

        // flush with two queued entries
        if2.stall = '0;
        if2.mem_to_wb_bus = {ln(32'h404, 1'b1, 5'd6, 32'h44), ln(32'h400, 1'b1, 5'd5, 32'h40)};
        step();
        if2.mem_to_wb_bus = {ln(32'h40C, 1'b1, 5'd8, 32'h4C), ln(32'h408, 1'b1, 5'd7, 32'h48)};
        step();
        chk("fl_pc0", if2.debug_wb_pc, 32'h400);
        if2.stall = 6'b110000;
        step();
        chk("fl_pc1", if2.debug_wb_pc, 32'h404);
        if2.flush = 1'b1;
        step();
        if2.flush = 1'b0;
        chk("fl_rf",  if2.wb_to_rf_bus, 0);
        chk("fl_pc2", if2.debug_wb_pc, 32'h408);
        step();
        chk("fl_pc3",  if2.debug_wb_pc, 32'h40C);
        chk("fl_wen3", if2.debug_wb_rf_wen, 4'hF);
        step();
        chk("fl_wen_end", if2.debug_wb_rf_wen, 0);

        // reset with three entries queued
        if2.stall = '0;
        for (int c = 0; c < 3; c++) begin
            if2.mem_to_wb_bus = {ln(32'h500 + 32'(8*c + 4), 1'b1, 5'(10 + 2*c), 32'(c + 1)),
                                 ln(32'h500 + 32'(8*c),     1'b1, 5'(9 + 2*c),  32'(c))};
            step();
        end
        if2.stall = 6'b110000;
        step();
        chk("rq_sr",  if2.stallreq_wb, 1);
        chk("rq_pc",  if2.debug_wb_pc, 32'h508);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rq_wen",   if2.debug_wb_rf_wen, 0);
        chk("rq_pc0",   if2.debug_wb_pc, 0);
        chk("rq_wnum",  if2.debug_wb_rf_wnum, 0);
        chk("rq_wdata", if2.debug_wb_rf_wdata, 0);
        chk("rq_sr0",   if2.stallreq_wb, 0);
        chk("rq_rf",    if2.wb_to_rf_bus, 0);
        if2.stall = '0;
        if2.mem_to_wb_bus = {ln(32'h0, 1'b0, 5'd0, 32'd0), ln(32'h600, 1'b1, 5'd11, 32'h66)};
        step();
        if2.mem_to_wb_bus = '0;
        step();
        chk("rq_new_pc",  if2.debug_wb_pc, 32'h600);
        chk("rq_new_wen", if2.debug_wb_rf_wen, 4'hF);
        step();
        chk("rq_empty", if2.debug_wb_rf_wen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
